postfix_evaluator: RTL

Receiver/consumer for the postfix token stream emitted by the infix-to-postfix converter; evaluates one expression per FIN_STB using an internal operand stack. Accepts operand and operator tokens over a strobe/acknowledge handshake, applies + - * / on signed WIDTH-bit values and reports the result or an error code. Sits downstream of the converter in the testbench datapath; stack storage is local (register array), not the shared stack module.

---
 rtl/postfix_evaluator.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/postfix_evaluator.sv
// Postfix expression evaluator with a local operand stack.
// Define POSTFIX_SAT_EN to saturate + - * and MIN/-1 instead of wrapping.
module postfix_evaluator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_DAT,
  input  logic             IN_TYPE,
  input  logic             IN_STB,
  output logic             IN_ACK,
  input  logic             FIN_STB,
  output logic             FIN_ACK,
  output logic             BUSY,
  output logic             DONE_STB,
  output logic [WIDTH-1:0] RESULT,
  output logic [2:0]       ERR_CODE
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;

  localparam logic [2:0] E_UNDER = 3'd1;
  localparam logic [2:0] E_OVER  = 3'd2;
  localparam logic [2:0] E_DIV0  = 3'd3;
  localparam logic [2:0] E_BADOP = 3'd4;

  localparam logic signed [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
`ifdef POSTFIX_SAT_EN
  localparam logic signed [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_DIV = SMAX;
`else
  localparam logic signed [WIDTH-1:0] MIN_DIV = SMIN;
`endif

  logic [2:0]              state;
  logic [CNT_W-1:0]        sp;
  logic [2:0]              err;
  logic [7:0]              tok;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic [WIDTH-1:0]        stk [DEPTH];

  logic [AW-1:0]           i_sp;
  logic [AW-1:0]           i_top;
  logic [AW-1:0]           i_nxt;
  logic                    full;
  logic                    op_ok;
  logic                    div0;
  logic signed [WIDTH-1:0] r_add;
  logic signed [WIDTH-1:0] r_sub;
  logic signed [WIDTH-1:0] r_mul;
  logic signed [WIDTH-1:0] quo;
  logic signed [WIDTH-1:0] res;

  assign i_sp  = sp[AW-1:0];
  assign i_top = i_sp - AW'(1);
  assign i_nxt = i_sp - AW'(2);
  assign full  = (sp == CNT_W'(DEPTH));
  assign op_ok = (tok == OP_ADD) || (tok == OP_SUB) ||
                 (tok == OP_MUL) || (tok == OP_DIV);
  assign div0  = (tok == OP_DIV) && (b == '0);
  assign BUSY  = (state != S_IDLE);

`ifdef POSTFIX_SAT_EN
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [2*WIDTH-1:0] mul_w;
  logic [WIDTH:0]     mul_hi;

  // Full-width results clipped to the signed range on overflow
  always_comb begin
    sum_w  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    dif_w  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    mul_w  = {{WIDTH{a[WIDTH-1]}}, a} *
             {{WIDTH{b[WIDTH-1]}}, b};
    mul_hi = mul_w[2*WIDTH-1:WIDTH-1];
    r_add  = sum_w[WIDTH-1:0];
    r_sub  = dif_w[WIDTH-1:0];
    r_mul  = mul_w[WIDTH-1:0];
    if (sum_w[WIDTH] != sum_w[WIDTH-1])
      r_add = sum_w[WIDTH] ? SMIN : SMAX;
    if (dif_w[WIDTH] != dif_w[WIDTH-1])
      r_sub = dif_w[WIDTH] ? SMIN : SMAX;
    if ((mul_hi != '0) && (mul_hi != '1))
      r_mul = mul_w[2*WIDTH-1] ? SMIN : SMAX;
  end
`else
  // Wrapping arithmetic keeps the low WIDTH bits
  always_comb begin
    r_add = a + b;
    r_sub = a - b;
    r_mul = a * b;
  end
`endif

  // Operator select; MIN/-1 special-cased, zero divisor yields 0
  always_comb begin
    quo = '0;
    if (b == '0)
      quo = '0;
    else if ((a == SMIN) && (b == '1))
      quo = MIN_DIV;
    else
      quo = a / b;
    res = quo;
    unique case (1'b1)
      (tok == OP_ADD): res = r_add;
      (tok == OP_SUB): res = r_sub;
      (tok == OP_MUL): res = r_mul;
      default:         res = quo;
    endcase
  end

  // Stack storage: push operands, replace the deeper entry on exec
  always_ff @(posedge CLK) begin
    if (RST) begin
      if ((state == S_PUSH) && !full)
        stk[i_sp] <= {{(WIDTH-8){1'b0}}, tok};
      else if ((state == S_EXEC) && !div0)
        stk[i_nxt] <= res;
    end
  end

  // Control FSM, handshakes and result registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      sp       <= '0;
      err      <= '0;
      tok      <= '0;
      a        <= '0;
      b        <= '0;
      IN_ACK   <= 1'b0;
      FIN_ACK  <= 1'b0;
      DONE_STB <= 1'b0;
      RESULT   <= '0;
      ERR_CODE <= '0;
    end else begin
      IN_ACK   <= 1'b0;
      FIN_ACK  <= 1'b0;
      DONE_STB <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IN_STB) begin
            tok    <= IN_DAT;
            IN_ACK <= 1'b1;
            state  <= IN_TYPE ? S_POP : S_PUSH;
          end else if (FIN_STB) begin
            FIN_ACK <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_PUSH: begin
          if (full) begin
            err   <= E_OVER;
            state <= S_DRAIN;
          end else begin
            sp    <= sp + CNT_W'(1);
            state <= S_IDLE;
          end
        end
        S_POP: begin
          if (!op_ok) begin
            err   <= E_BADOP;
            state <= S_DRAIN;
          end else if (sp < CNT_W'(2)) begin
            err   <= E_UNDER;
            state <= S_DRAIN;
          end else begin
            b     <= stk[i_top];
            a     <= stk[i_nxt];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (div0) begin
            err   <= E_DIV0;
            state <= S_DRAIN;
          end else begin
            sp    <= sp - CNT_W'(1);
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (IN_STB && !IN_ACK) begin
            IN_ACK <= 1'b1;
          end else if (FIN_STB && !IN_ACK) begin
            FIN_ACK <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          DONE_STB <= 1'b1;
          if (err != '0) begin
            ERR_CODE <= err;
            RESULT   <= '0;
          end else if (sp == CNT_W'(1)) begin
            ERR_CODE <= '0;
            RESULT   <= stk[0];
          end else begin
            ERR_CODE <= E_UNDER;
            RESULT   <= '0;
          end
          sp    <= '0;
          err   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
